// File: rtl/cpu_run_monitor.sv
// Supervises one run of a core: holds it in reset, releases it, watches the PC
// for a halt (PC stable) or a cycle-budget timeout, then latches the outcome.
module cpu_run_monitor #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int RESET_CYCLES  = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_CYCLES    = 100,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] pcw,
    input  logic [DATA_WIDTH-1:0]    result,
    input  logic [DATA_WIDTH-1:0]    expected,
    output logic                     core_rst,
    output logic                     running,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [CNT_WIDTH-1:0]     cycle_count,
    output logic [ADDRESS_WIDTH-1:0] halt_pc,
    output logic [DATA_WIDTH-1:0]    final_result
);

    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES - 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t                   state, state_n;
    logic [RW-1:0]            reset_cnt, reset_cnt_n;
    logic [SW-1:0]            stable_cnt, stable_cnt_n;
    logic [ADDRESS_WIDTH-1:0] last_pc, last_pc_n;

    logic                     core_rst_n, running_n, done_n, pass_n, timeout_n;
    logic [CNT_WIDTH-1:0]     cycle_count_n;
    logic [ADDRESS_WIDTH-1:0] halt_pc_n;
    logic [DATA_WIDTH-1:0]    final_result_n;

    logic same_pc, halt, budget_end;

    always_comb begin
        same_pc    = (pcw == last_pc);
        halt       = same_pc && (stable_cnt == SW'(STABLE_CYCLES - 2));
        budget_end = (cycle_count == CNT_WIDTH'(MAX_CYCLES - 1));

        state_n        = state;
        reset_cnt_n    = reset_cnt;
        stable_cnt_n   = stable_cnt;
        last_pc_n      = last_pc;
        pass_n         = pass;
        timeout_n      = timeout;
        cycle_count_n  = cycle_count;
        halt_pc_n      = halt_pc;
        final_result_n = final_result;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_RESET;
                    reset_cnt_n = '0;
                end
            end
            S_RESET: begin
                if (reset_cnt == RW'(RESET_CYCLES - 1)) begin
                    state_n       = S_RUN;
                    cycle_count_n = '0;
                    stable_cnt_n  = '0;
                    last_pc_n     = '0;
                end else begin
                    reset_cnt_n = reset_cnt + 1'b1;
                end
            end
            S_RUN: begin
                cycle_count_n = cycle_count + 1'b1;
                last_pc_n     = pcw;
                if (!same_pc) begin
                    stable_cnt_n = '0;
                end else if (!halt) begin
                    stable_cnt_n = stable_cnt + 1'b1;
                end
                // Halt has priority when it coincides with the last budget cycle.
                if (halt || budget_end) begin
                    state_n        = S_DONE;
                    halt_pc_n      = pcw;
                    final_result_n = result;
                    timeout_n      = !halt;
                    pass_n         = halt && (result == expected);
                end
            end
            S_DONE: begin
                if (start) begin
                    state_n     = S_RESET;
                    reset_cnt_n = '0;
                    pass_n      = 1'b0;
                    timeout_n   = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        core_rst_n = (state_n != S_RUN);
        running_n  = (state_n == S_RUN);
        done_n     = (state_n == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            reset_cnt    <= '0;
            stable_cnt   <= '0;
            last_pc      <= '0;
            core_rst     <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            halt_pc      <= '0;
            final_result <= '0;
        end else begin
            state        <= state_n;
            reset_cnt    <= reset_cnt_n;
            stable_cnt   <= stable_cnt_n;
            last_pc      <= last_pc_n;
            core_rst     <= core_rst_n;
            running      <= running_n;
            done         <= done_n;
            pass         <= pass_n;
            timeout      <= timeout_n;
            cycle_count  <= cycle_count_n;
            halt_pc      <= halt_pc_n;
            final_result <= final_result_n;
        end
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed vector table, reset/abort sequences and
// randomized traffic, all checked against a behavioural model every cycle.
module tb_cpu_run_monitor;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RC = 2;
    localparam int SC = 4;
    localparam int MC = 100;
    localparam int CW = 16;

    localparam int P_IDLE  = 0;
    localparam int P_RESET = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] pcw = '0;
    logic [DW-1:0] result = '0;
    logic [DW-1:0] expected = '0;
    logic          core_rst, running, done, pass, timeout;
    logic [CW-1:0] cycle_count;
    logic [AW-1:0] halt_pc;
    logic [DW-1:0] final_result;

    cpu_run_monitor #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .RESET_CYCLES (RC),
        .STABLE_CYCLES(SC),
        .MAX_CYCLES   (MC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pcw         (pcw),
        .result      (result),
        .expected    (expected),
        .core_rst    (core_rst),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .halt_pc     (halt_pc),
        .final_result(final_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: run phase, PC history queue, run-cycle number.
    int            m_phase = P_IDLE;
    int            m_rcnt = 0;
    int            m_n = 0;
    logic [AW-1:0] m_hist[$];
    bit            m_done = 0, m_pass = 0, m_to = 0;
    int            m_count = 0;
    logic [AW-1:0] m_hpc = '0;
    logic [DW-1:0] m_fres = '0;

    task automatic model_reset();
        m_phase = P_IDLE; m_rcnt = 0; m_n = 0; m_hist.delete();
        m_done = 0; m_pass = 0; m_to = 0; m_count = 0; m_hpc = '0; m_fres = '0;
    endtask

    task automatic model_step();
        bit halt;
        case (m_phase)
            P_IDLE: if (start) begin m_phase = P_RESET; m_rcnt = 0; end
            P_RESET: begin
                m_rcnt++;
                if (m_rcnt == RC) begin
                    m_phase = P_RUN; m_n = 0; m_count = 0;
                    m_hist.delete(); m_hist.push_back('0);
                end
            end
            P_RUN: begin
                m_n++;
                m_count = m_n;
                m_hist.push_back(pcw);
                if (m_hist.size() > SC) void'(m_hist.pop_front());
                halt = (m_hist.size() >= SC);
                foreach (m_hist[i]) if (m_hist[i] != pcw) halt = 0;
                if (halt || m_n == MC) begin
                    m_phase = P_DONE; m_done = 1; m_to = !halt;
                    m_pass = halt && (result == expected);
                    m_hpc = pcw; m_fres = result;
                end
            end
            default: if (start) begin
                m_phase = P_RESET; m_rcnt = 0; m_done = 0; m_pass = 0; m_to = 0;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("mon core_rst", core_rst, m_phase != P_RUN);
            chk("mon running", running, m_phase == P_RUN);
            chk("mon done", done, m_done);
            chk("mon pass", pass, m_pass);
            chk("mon timeout", timeout, m_to);
            chk("mon cycle_count", cycle_count, m_count);
            chk("mon halt_pc", halt_pc, m_hpc);
            chk("mon final_result", final_result, m_fres);
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, " core_rst"}, core_rst, 1);
        chk({tag, " running"}, running, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " pass"}, pass, 0);
        chk({tag, " timeout"}, timeout, 0);
        chk({tag, " cycle_count"}, cycle_count, 0);
        chk({tag, " halt_pc"}, halt_pc, 0);
        chk({tag, " final_result"}, final_result, 0);
    endtask

    // pcw = 4*(k-1) for RUN cycles k <= inc, then spc; optional start pulse and abort.
    task automatic run_pattern(input int inc, input logic [AW-1:0] spc,
                               input logic [DW-1:0] res, input logic [DW-1:0] exp_v,
                               input int start_at, input int abort_at,
                               output int rlen, output bit finished);
        result = res; expected = exp_v;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        rlen = 0;
        finished = 0;
        for (int g = 0; g < 20 && !running; g++) begin
            if (core_rst) rlen++;
            @(negedge clk);
        end
        for (int k = 1; k <= MC + 10; k++) begin
            pcw = (k <= inc) ? AW'(4 * (k - 1)) : spc;
            start = (k == start_at);
            if (k == abort_at) begin
                #2 rst = 1'b0;
                #1 check_reset_values("abort");
                @(negedge clk); #2 rst = 1'b1;
                start = 1'b0;
                return;
            end
            @(negedge clk);
            if (done) begin finished = 1; break; end
        end
        start = 1'b0;
    endtask

    typedef struct {
        int            inc;
        logic [AW-1:0] spc;
        logic [DW-1:0] res;
        logic [DW-1:0] exp_v;
        int            e_cnt;
        bit            e_pass;
        bit            e_to;
        logic [AW-1:0] e_hpc;
    } vec_t;

    vec_t tbl[7];
    int   rlen;
    bit   fin;
    int   hold;

    initial begin
        tbl[0] = '{4,   32'h10,   32'h2A, 32'h2A, 8,   1, 0, 32'h10};
        tbl[1] = '{4,   32'h10,   32'h2A, 32'h2B, 8,   0, 0, 32'h10};
        tbl[2] = '{0,   32'h0,    32'h55, 32'h55, 3,   1, 0, 32'h0};
        tbl[3] = '{1,   32'h40,   32'h7,  32'h7,  5,   1, 0, 32'h40};
        tbl[4] = '{200, 32'h0,    32'h2A, 32'h2A, 100, 0, 1, 32'h18C};
        tbl[5] = '{96,  32'h1000, 32'h99, 32'h99, 100, 1, 0, 32'h1000};
        tbl[6] = '{97,  32'h2000, 32'h3,  32'h3,  100, 0, 1, 32'h2000};

        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_values("idle");

        foreach (tbl[i]) begin
            run_pattern(tbl[i].inc, tbl[i].spc, tbl[i].res, tbl[i].exp_v, 0, 0, rlen, fin);
            chk($sformatf("v%0d finished", i), fin, 1);
            chk($sformatf("v%0d reset_len", i), rlen, RC);
            chk($sformatf("v%0d cycle_count", i), cycle_count, tbl[i].e_cnt);
            chk($sformatf("v%0d pass", i), pass, tbl[i].e_pass);
            chk($sformatf("v%0d timeout", i), timeout, tbl[i].e_to);
            chk($sformatf("v%0d halt_pc", i), halt_pc, tbl[i].e_hpc);
            chk($sformatf("v%0d final_result", i), final_result, tbl[i].res);
            chk($sformatf("v%0d core_rst", i), core_rst, 1);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d hold count", i), cycle_count, tbl[i].e_cnt);
        end

        run_pattern(200, 32'h0, 32'h2A, 32'h2A, 10, 30, rlen, fin);
        chk("abort no done", fin, 0);
        repeat (5) @(negedge clk);
        check_reset_values("post abort");
        run_pattern(4, 32'h10, 32'h2A, 32'h2A, 3, 0, rlen, fin);
        chk("rerun finished", fin, 1);
        chk("rerun cycle_count", cycle_count, 8);
        chk("rerun pass", pass, 1);

        hold = 75;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 250 == 0) hold = $urandom_range(50, 95);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) >= hold) pcw = AW'($urandom_range(0, 3) * 4);
            result = $urandom_range(0, 1) ? 32'h2A : 32'h2B;
            expected = $urandom_range(0, 1) ? 32'h2A : 32'h2B;
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk); #2 rst = 1'b1;
            end
        end
        start = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
